// File: rtl/event_counter_pkg.sv
// Shared types and limits for the event counter bank.
// Read FSM state encoding and parameter range constants.
package event_counter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    ACK
  } rd_state_t;

  localparam int EC_MAX_CH    = 16;
  localparam int EC_MAX_CNT_W = 32;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_counter_ch.sv
// One saturating event counter with sticky overflow.
// A clear reloads the count with the coincident event.
module event_counter_ch #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             evt,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= {{(CNT_W-1){1'b0}}, evt};
      ovf   <= 1'b0;
    end else if (evt) begin
      if (&count) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_counter_bank.sv
// Per-channel event counter bank with a req/ack snapshot read port.
// Optional threshold interrupt IRQ_O built with EVENT_IRQ_EN.
module event_counter_bank
  import event_counter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int IRQ_THRESH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_CH-1:0]             EVT_I,
  input  logic                          RD_REQ_I,
  input  logic [ch_idx_w(NUM_CH)-1:0]   RD_CH_I,
  input  logic                          RD_CLR_I,
  output logic                          RD_BUSY_O,
  output logic                          RD_ACK_O,
  output logic [CNT_W-1:0]              RD_DATA_O,
  output logic                          RD_OVF_O,
  output logic [NUM_CH-1:0]             PENDING_O
`ifdef EVENT_IRQ_EN
  ,
  output logic                          IRQ_O
`endif
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > EC_MAX_CH) begin : g_bad_ch
    $error("NUM_CH out of range");
  end
  if (CNT_W < 2 || CNT_W > EC_MAX_CNT_W) begin : g_bad_w
    $error("CNT_W out of range");
  end
  if (longint'(IRQ_THRESH) >= (longint'(1) << CNT_W)) begin : g_bad_th
    $error("IRQ_THRESH too large");
  end

  rd_state_t        state;
  logic [CH_W-1:0]  ch_q;
  logic             clr_q;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [NUM_CH-1:0] ovf_v;
  logic [NUM_CH-1:0] clr_v;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_ovf;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign clr_v[g] = (state == CAPTURE) && clr_q
                    && (ch_q == CH_W'(g));
    assign PENDING_O[g] = |cnt[g];

    event_counter_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .CLK  (CLK),
      .RESET(RESET),
      .evt  (EVT_I[g]),
      .clr  (clr_v[g]),
      .count(cnt[g]),
      .ovf  (ovf_v[g])
    );
  end

  // Out-of-range channel numbers match nothing and read as zero.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_cnt = cnt[i];
        sel_ovf = ovf_v[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ch_q      <= '0;
      clr_q     <= 1'b0;
      RD_BUSY_O <= 1'b0;
      RD_ACK_O  <= 1'b0;
      RD_DATA_O <= '0;
      RD_OVF_O  <= 1'b0;
    end else begin
      RD_ACK_O <= 1'b0;
      unique case (state)
        IDLE: begin
          if (RD_REQ_I) begin
            ch_q      <= RD_CH_I;
            clr_q     <= RD_CLR_I;
            RD_BUSY_O <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          RD_DATA_O <= sel_cnt;
          RD_OVF_O  <= sel_ovf;
          RD_ACK_O  <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          RD_BUSY_O <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EVENT_IRQ_EN
  logic irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      irq_d |= (cnt[i] >= CNT_W'(IRQ_THRESH)) | ovf_v[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) IRQ_O <= 1'b0;
    else       IRQ_O <= irq_d;
  end
`endif

endmodule
